// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm countdown timer.
package alarm_pkg;

  localparam int DEFAULT_WIDTH    = 10;
  localparam int DEFAULT_TICK_DIV = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_EXPIRED
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clock50 down to a one-cycle tick strobe every TICK_DIV enabled cycles.
module tick_prescaler
  import alarm_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clock50,
  input  logic Mr,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The strobe is high during the cycle whose closing edge wraps the counter.
  assign tick = enable && !clear && (cnt_q == LAST);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock50 or posedge Mr) begin
    if (Mr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_countdown.sv
// Tick-based countdown alarm: start/pause/cancel control, one-cycle Tz at zero.
module alarm_countdown
  import alarm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clock50,
  input  logic             Mr,
  input  logic             start,
  input  logic             pause,
  input  logic             cancel,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] Qout,
  output logic             running,
  output logic             Tz,
  output logic             expired
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic             tz_q, tz_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;

  logic presc_clear;
  logic presc_enable;
  logic tick;

  // A pause-high cycle freezes the prescaler, so a coinciding tick never fires.
  assign presc_clear  = cancel || start;
  assign presc_enable = ((state_q == ST_RUN) || (state_q == ST_HOLD)) && !pause && !presc_clear;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock50 (clock50),
    .Mr      (Mr),
    .clear   (presc_clear),
    .enable  (presc_enable),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    qout_d  = qout_q;
    tz_d    = 1'b0;

    if (cancel) begin
      state_d = ST_IDLE;
      qout_d  = '0;
    end else if (start) begin
      if (load_value == '0) begin
        state_d = ST_EXPIRED;
        qout_d  = '0;
        tz_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
        qout_d  = load_value;
      end
    end else begin
      case (state_q)
        ST_RUN, ST_HOLD: begin
          state_d = pause ? ST_HOLD : ST_RUN;
          if (tick) begin
            if (qout_q > WIDTH'(1)) begin
              qout_d = qout_q - WIDTH'(1);
            end else begin
              qout_d  = '0;
              state_d = ST_EXPIRED;
              tz_d    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // Status flags are decoded from the next state so they leave a flop.
    running_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clock50 or posedge Mr) begin
    if (Mr) begin
      state_q   <= ST_IDLE;
      qout_q    <= '0;
      tz_q      <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qout_q    <= qout_d;
      tz_q      <= tz_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign Qout    = qout_q;
  assign running = running_q;
  assign Tz      = tz_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_alarm_countdown.sv
// Self-checking bench for alarm_countdown with a cycles-remaining reference model.
module tb_alarm_countdown;

  localparam int WIDTH    = 10;
  localparam int TICK_DIV = 4;

  logic             clock50 = 1'b0;
  logic             Mr;
  logic             start;
  logic             pause;
  logic             cancel;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Qout;
  logic             running;
  logic             Tz;
  logic             expired;

  int checks = 0;
  int errors = 0;

  alarm_countdown #(
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clock50    (clock50),
    .Mr         (Mr),
    .start      (start),
    .pause      (pause),
    .cancel     (cancel),
    .load_value (load_value),
    .Qout       (Qout),
    .running    (running),
    .Tz         (Tz),
    .expired    (expired)
  );

  always #5 clock50 = ~clock50;

  // Reference model: the alarm is a pool of clock50 cycles still to elapse.
  // Qout is that pool expressed in whole ticks, rounded up.
  typedef enum {M_IDLE, M_COUNT, M_DONE} mode_t;
  mode_t m_mode;
  int    m_rem;
  logic  m_tz;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_rem  = 0;
    m_tz   = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic s, input logic p,
                            input logic [WIDTH-1:0] lv);
    m_tz = 1'b0;
    if (c) begin
      m_mode = M_IDLE;
      m_rem  = 0;
    end else if (s) begin
      if (lv == '0) begin
        m_mode = M_DONE;
        m_rem  = 0;
        m_tz   = 1'b1;
      end else begin
        m_mode = M_COUNT;
        m_rem  = int'(lv) * TICK_DIV;
      end
    end else if (m_mode == M_COUNT && !p) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_mode = M_DONE;
        m_tz   = 1'b1;
      end
    end
  endtask

  function automatic logic [WIDTH+2:0] exp_vec();
    logic [WIDTH-1:0] q;
    q = WIDTH'((m_rem + TICK_DIV - 1) / TICK_DIV);
    return {q, m_mode == M_COUNT, m_tz, m_mode == M_DONE};
  endfunction

  logic [WIDTH+2:0] act_vec;
  assign act_vec = {Qout, running, Tz, expired};

  // Drive one cycle of inputs, advance through the edge, settle before sampling.
  task automatic tick(input logic c, input logic s, input logic p,
                      input logic [WIDTH-1:0] lv);
    cancel     = c;
    start      = s;
    pause      = p;
    load_value = lv;
    @(posedge clock50);
    model_step(c, s, p, lv);
    #1;
  endtask

  task automatic test_reset();
    Mr = 1'b1;
    cancel = 1'b0; start = 1'b0; pause = 1'b0; load_value = '0;
    model_reset();
    repeat (2) @(posedge clock50);
    #1;
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL reset_hold: {Qout,running,Tz,expired} got %h expected 0", act_vec);
    end
    Mr = 1'b0;
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_basic_countdown();
    int tz_at    = -1;
    int tz_count = 0;
    tick(1'b0, 1'b1, 1'b0, 10'd3);
    checks++;
    if (Qout !== 10'd3 || running !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: Qout=%0d running=%b expected 3/1", Qout, running);
    end
    for (int n = 1; n <= 12; n++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL basic_cycle%0d: got %h expected %h", n, act_vec, exp_vec());
      end
      if (Tz === 1'b1) begin
        tz_count++;
        if (tz_at < 0) tz_at = n;
      end
    end
    checks++;
    if (tz_at !== 12) begin
      errors++;
      $display("FAIL basic_tz_latency: Tz at cycle %0d expected 12", tz_at);
    end
    repeat (5) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      if (Tz === 1'b1) tz_count++;
    end
    checks++;
    if (tz_count !== 1) begin
      errors++;
      $display("FAIL basic_tz_count: %0d pulses expected 1", tz_count);
    end
    checks++;
    if (expired !== 1'b1 || Qout !== '0) begin
      errors++;
      $display("FAIL basic_expired_hold: expired=%b Qout=%0d expected 1/0", expired, Qout);
    end
  endtask

  task automatic test_pause();
    int tz_at = -1;
    tick(1'b0, 1'b1, 1'b0, 10'd5);
    for (int n = 1; n <= 6; n++) tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (Qout !== 10'd4) begin
      errors++;
      $display("FAIL pause_pre: Qout=%0d expected 4", Qout);
    end
    for (int n = 7; n <= 16; n++) begin
      tick(1'b0, 1'b0, 1'b1, '0);
      checks++;
      if (Qout !== 10'd4 || running !== 1'b1 || Tz !== 1'b0) begin
        errors++;
        $display("FAIL pause_frozen%0d: Qout=%0d running=%b Tz=%b expected 4/1/0",
                 n, Qout, running, Tz);
      end
    end
    for (int n = 17; n <= 46 && tz_at < 0; n++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pause_resume%0d: got %h expected %h", n, act_vec, exp_vec());
      end
      if (Tz === 1'b1) tz_at = n;
    end
    checks++;
    if (tz_at !== 30) begin
      errors++;
      $display("FAIL pause_tz_latency: Tz at cycle %0d expected 30", tz_at);
    end
  endtask

  task automatic test_zero_load();
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (Tz !== 1'b1) begin
      errors++;
      $display("FAIL zero_tz: Tz=%b expected 1", Tz);
    end
    checks++;
    if (expired !== 1'b1 || running !== 1'b0 || Qout !== '0) begin
      errors++;
      $display("FAIL zero_flags: expired=%b running=%b Qout=%0d expected 1/0/0",
               expired, running, Qout);
    end
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (Tz !== 1'b0 || expired !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse_width: Tz=%b expired=%b expected 0/1", Tz, expired);
    end
  endtask

  task automatic test_cancel_restart();
    int tz_at = -1;
    tick(1'b0, 1'b1, 1'b0, 10'd1023);
    repeat (9) tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL cancel_idle: {Qout,running,Tz,expired} got %h expected 0", act_vec);
    end
    repeat (3) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL cancel_stay_idle: got %h expected %h", act_vec, exp_vec());
      end
    end
    tick(1'b0, 1'b1, 1'b0, 10'd2);
    for (int n = 1; n <= 20 && tz_at < 0; n++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      if (Tz === 1'b1) tz_at = n;
    end
    checks++;
    if (tz_at !== 8) begin
      errors++;
      $display("FAIL cancel_restart_latency: Tz at cycle %0d expected 8", tz_at);
    end
  endtask

  task automatic test_async_reset();
    int tz_count = 0;
    tick(1'b0, 1'b1, 1'b0, 10'd6);
    repeat (5) tick(1'b0, 1'b0, 1'b0, '0);
    #3;
    Mr = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL mr_immediate: got %h expected 0", act_vec);
    end
    @(posedge clock50);
    #1;
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL mr_hold: got %h expected 0", act_vec);
    end
    #2;
    Mr = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL mr_after%0d: got %h expected %h", n, act_vec, exp_vec());
      end
      if (Tz === 1'b1) tz_count++;
    end
    checks++;
    if (tz_count !== 0) begin
      errors++;
      $display("FAIL mr_no_tz: %0d pulses expected 0", tz_count);
    end
  endtask

  task automatic test_start_on_final_tick();
    int tz_at = -1;
    tick(1'b0, 1'b1, 1'b0, 10'd2);
    repeat (7) tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, 10'd7);
    checks++;
    if (Tz !== 1'b0 || Qout !== 10'd7 || running !== 1'b1) begin
      errors++;
      $display("FAIL final_tick_restart: Tz=%b Qout=%0d running=%b expected 0/7/1",
               Tz, Qout, running);
    end
    for (int n = 1; n <= 40 && tz_at < 0; n++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      if (Tz === 1'b1) tz_at = n;
    end
    checks++;
    if (tz_at !== 28) begin
      errors++;
      $display("FAIL final_tick_new_latency: Tz at cycle %0d expected 28", tz_at);
    end
  endtask

  task automatic test_random();
    logic             c, s, p;
    logic [WIDTH-1:0] lv;
    for (int n = 0; n < 800; n++) begin
      c  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 6);
      p  = ($urandom_range(0, 99) < 25);
      lv = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 1))
                                       : WIDTH'($urandom_range(0, 6));
      tick(c, s, p, lv);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d (c=%b s=%b p=%b lv=%0d): got %h expected %h",
                 n, c, s, p, lv, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_pause();
    test_zero_load();
    test_cancel_restart();
    test_async_reset();
    test_start_on_final_tick();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
